equiv_vec_sched: RTL and testbench

Synthesizable stimulus scheduler for netlist equivalence runs. It accepts a stream of packed input vectors and applies each one to two DUT instances (pre- and post-synthesis `top`) through a shared input bus. After a programmable settle time it captures and compares their `y` outputs and folds the reference output into a 32-bit signature. It sits between a vector source (ROM, FIFO or host) and the pair of DUTs, and replaces free-running testbench timing with a cycle-exact, handshaked sequence.

---
 rtl/equiv_vec_sched_pkg.sv | 11 +
 rtl/equiv_vec_sched_sig_misr.sv | 16 +
 rtl/equiv_vec_sched.sv | 94 +++++++++
 tb/tb_equiv_vec_sched.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/equiv_vec_sched_pkg.sv
// equiv_vec_sched_pkg: shared state encoding, signature polynomial and output fold.
package equiv_vec_sched_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_CAPTURE, S_DONE} state_t;
  localparam logic [31:0] SIG_POLY = 32'h04C11DB7;
  function automatic logic [31:0] fold256(input logic [255:0] v);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < 8; i++) f ^= v[i*32 +: 32];
    return f;
  endfunction
endpackage

// File: rtl/equiv_vec_sched_sig_misr.sv
// sig_misr: 32-bit shift-and-fold signature register with synchronous clear.
module sig_misr
  import equiv_vec_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic [31:0] data,
  output logic [31:0] sig
);
  always_ff @(posedge clk or posedge rst)
    if (rst) sig <= '0;
    else if (clear) sig <= '0;
    else if (en) sig <= {sig[30:0], 1'b0} ^ (sig[31] ? SIG_POLY : 32'h0) ^ data;
endmodule

// File: rtl/equiv_vec_sched.sv
// equiv_vec_sched: handshaked vector scheduler comparing two DUTs after a settle delay.
// Define EQUIV_VEC_SCHED_STOP_ON_MISMATCH_EN to end the run at the first mismatching capture.
module equiv_vec_sched
  import equiv_vec_sched_pkg::*;
#(
  parameter int IN_W   = 68,
  parameter int OUT_W  = 255,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vec_valid,
  input  logic [IN_W-1:0]  vec_data,
  input  logic             vec_last,
  output logic             vec_ready,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] y_a,
  input  logic [OUT_W-1:0] y_b,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [15:0]      mismatch_idx,
  output logic [15:0]      vec_count,
  output logic [31:0]      sig
);
  localparam logic [3:0] SC = 4'(SETTLE == 0 ? 0 : SETTLE - 1);
  state_t state, nxt;
  logic [3:0] cnt;
  logic last, miss, stop, clr, acc, cap;
  logic [31:0] fold;
  assign miss = y_a != y_b;
  assign clr  = (state == S_IDLE || state == S_DONE) && start;
  assign acc  = state == S_LOAD && vec_valid;
  assign cap  = state == S_CAPTURE;
  assign fold = fold256(256'(y_a));
`ifdef EQUIV_VEC_SCHED_STOP_ON_MISMATCH_EN
  assign stop = miss;
`else
  assign stop = 1'b0;
`endif
  assign vec_ready = state == S_LOAD;
  assign busy      = state == S_LOAD || state == S_SETTLE || state == S_CAPTURE;
  assign done      = state == S_DONE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE: nxt = start ? S_LOAD : state;
      S_LOAD:         nxt = vec_valid ? (SETTLE == 0 ? S_CAPTURE : S_SETTLE) : S_LOAD;
      S_SETTLE:       nxt = cnt == 4'd0 ? S_CAPTURE : S_SETTLE;
      S_CAPTURE:      nxt = (last || stop) ? S_DONE : S_LOAD;
      default:        nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dut_in       <= '0;
      last         <= 1'b0;
      cnt          <= '0;
      mismatch     <= 1'b0;
      mismatch_idx <= '0;
      vec_count    <= '0;
    end else begin
      if (clr) begin
        vec_count    <= '0;
        mismatch     <= 1'b0;
        mismatch_idx <= '0;
      end
      if (acc) begin
        dut_in <= vec_data;
        last   <= vec_last;
        cnt    <= SC;
      end
      if (state == S_SETTLE) cnt <= cnt - 4'd1;
      if (cap) begin
        vec_count <= vec_count + 16'd1;
        if (miss && !mismatch) begin
          mismatch     <= 1'b1;
          mismatch_idx <= vec_count;
        end
      end
    end
  sig_misr u_sig (
    .clk  (clk),
    .rst  (rst),
    .clear(clr),
    .en   (cap),
    .data (fold),
    .sig  (sig)
  );
endmodule

// File: tb/tb_equiv_vec_sched.sv
// tb_equiv_vec_sched: directed and randomized runs against a behavioural scheduler model.
module tb_equiv_vec_sched;
  logic clk = 0, rst = 1, start = 0, vec_valid = 0, vec_last = 0;
  logic [67:0] vec_data = '0, dut_in;
  logic [254:0] y_a, y_b;
  logic vec_ready, busy, done, mismatch;
  logic [15:0] mismatch_idx, vec_count;
  logic [31:0] sig;
  logic start0 = 0, vv0 = 0, vl0 = 0;
  logic [67:0] vd0 = '0, din0;
  logic rdy0, busy0, done0, mm0;
  logic [15:0] mmi0, cnt0;
  logic [31:0] sig0;
  int checks = 0, failures = 0, cyc = 0, ymode = 0, acc_cyc = 0, done_cyc = 0;
  int acc_hist[16];
  logic [67:0] vq[16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [254:0] yfun(input int mode, input logic [67:0] d);
    return mode == 1 ? 255'h1 : mode == 2 ? {d, d, d, d[50:0]} : mode == 3 ? 255'(d) : 255'h0;
  endfunction

  always_comb begin
    y_a = yfun(ymode, dut_in);
    y_b = y_a ^ ((ymode == 2 && dut_in[67]) ? 255'h1 : 255'h0);
  end

  equiv_vec_sched u_dut (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec_data(vec_data),
    .vec_last(vec_last), .vec_ready(vec_ready), .dut_in(dut_in), .y_a(y_a), .y_b(y_b),
    .busy(busy), .done(done), .mismatch(mismatch), .mismatch_idx(mismatch_idx),
    .vec_count(vec_count), .sig(sig)
  );

  equiv_vec_sched #(.SETTLE(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .vec_valid(vv0), .vec_data(vd0),
    .vec_last(vl0), .vec_ready(rdy0), .dut_in(din0), .y_a(255'(din0)), .y_b(255'(din0)),
    .busy(busy0), .done(done0), .mismatch(mm0), .mismatch_idx(mmi0),
    .vec_count(cnt0), .sig(sig0)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model(input int n, input int mode, output logic [31:0] s, output logic [15:0] c,
                       output logic m, output logic [15:0] mi);
    logic [254:0] ya, yb;
    logic [255:0] z;
    logic [31:0] f;
    s = 0; c = 0; m = 0; mi = 0;
    for (int k = 0; k < n; k++) begin
      ya = yfun(mode, vq[k]);
      yb = ya ^ ((mode == 2 && vq[k][67]) ? 255'h1 : 255'h0);
      z = {1'b0, ya};
      f = 0;
      for (int j = 0; j < 8; j++) f ^= z[j*32 +: 32];
      s = (s << 1) ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
      if (ya != yb && !m) begin m = 1; mi = c; end
      c++;
`ifdef EQUIV_VEC_SCHED_STOP_ON_MISMATCH_EN
      if (ya != yb) break;
`endif
    end
  endtask

  task automatic acc_one(input logic [67:0] d, input bit l, input bit gaps, output bit ok);
    bit hit;
    ok = 0;
    for (int g = 0; g < 200 && !ok && !done; g++) begin
      vec_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      vec_data = d;
      vec_last = l;
      hit = vec_ready && vec_valid;
      step();
      if (hit) begin ok = 1; acc_cyc = cyc; end
    end
    vec_valid = 0;
    if (ok) chk("dut_in_acc", dut_in, d);
  endtask

  task automatic run(input int n, input int mode, input bit gaps);
    logic [31:0] es;
    logic [15:0] ec, ei;
    logic em;
    bit ok;
    int g;
    model(n, mode, es, ec, em, ei);
    ymode = mode;
    start = 1;
    step();
    start = 0;
    chk("start_ready", vec_ready, 1);
    chk("start_cnt", vec_count, 0);
    chk("start_done", done, 0);
    for (int i = 0; i < n && !done; i++) begin
      acc_one(vq[i], i == n - 1, gaps, ok);
      acc_hist[i] = acc_cyc;
      if (!ok && !done) begin
        failures++;
        $error("FAIL accept_timeout observed=0 expected=1");
      end
    end
    g = 0;
    while (!done && g < 100) begin step(); g++; end
    done_cyc = cyc;
    chk("run_done", done, 1);
    chk("run_busy", busy, 0);
    chk("run_ready", vec_ready, 0);
    chk("run_cnt", vec_count, ec);
    chk("run_sig", sig, es);
    chk("run_mm", mismatch, em);
    chk("run_mmi", mismatch_idx, ei);
  endtask

  initial begin
    bit ok;
    logic [31:0] es;
    logic [15:0] ec, ei;
    logic em;
    step();
    chk("rst_dut_in", dut_in, 0);
    chk("rst_ready", vec_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sig", sig, 0);
    rst = 0;
    step();
    chk("idle_busy", busy, 0);
    chk("idle_cnt", vec_count, 0);

    for (int i = 0; i < 3; i++) vq[i] = {$urandom, $urandom, $urandom};
    run(3, 0, 0);
    chk("t1_sig", sig, 0);
    chk("t1_cnt", vec_count, 3);
    chk("t1_period", acc_hist[1] - acc_hist[0], 4);
    chk("t1_done_lat", done_cyc - acc_hist[0], 11);

    run(1, 1, 0);
    chk("t2_sig1", sig, 32'h1);
    run(2, 1, 0);
    chk("t2_sig3", sig, 32'h3);

    for (int i = 0; i < 5; i++) vq[i] = {(i == 2 || i == 4) ? 1'b1 : 1'b0, 3'(i), 64'($urandom)};
    run(5, 2, 0);
    chk("t3_mm", mismatch, 1);
    chk("t3_mmi", mismatch_idx, 2);
`ifdef EQUIV_VEC_SCHED_STOP_ON_MISMATCH_EN
    chk("t3_cnt", vec_count, 3);
`else
    chk("t3_cnt", vec_count, 5);
`endif

    ymode = 2;
    vq[0] = 68'h0_1234_5678_9ABC_DEF0;
    vq[1] = 68'h0_0FED_CBA9_8765_4321;
    start = 1;
    step();
    start = 0;
    acc_one(vq[0], 0, 0, ok);
    while (!vec_ready && cyc < 100000) step();
    chk("gap_cnt_before", vec_count, 1);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      step();
      chk("gap_ready", vec_ready, 1);
      chk("gap_dut_in", dut_in, vq[0]);
      chk("gap_cnt", vec_count, 1);
    end
    start = 0;
    acc_one(vq[1], 0, 0, ok);
    #2 rst = 1;
    #1;
    chk("mid_rst_dut_in", dut_in, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", vec_ready, 0);
    chk("mid_rst_cnt", vec_count, 0);
    chk("mid_rst_sig", sig, 0);
    chk("mid_rst_mm", {mismatch, mismatch_idx, done}, 0);
    #1 rst = 0;
    step();
    chk("post_rst_busy", busy, 0);
    vq[2] = 68'h0_5555_AAAA_0F0F_F0F0;
    run(3, 2, 0);

    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(3, 8);
      for (int i = 0; i < n; i++) vq[i] = {($urandom_range(0, 4) == 0), 3'($urandom), $urandom, $urandom};
      run(n, 2, 1);
    end

    vq[0] = 68'h3_2051_4C3E_7A90_87FC;
    for (int i = 1; i < 4; i++) vq[i] = {4'($urandom), $urandom, $urandom};
    model(4, 3, es, ec, em, ei);
    start0 = 1;
    step();
    start0 = 0;
    for (int i = 0; i < 4; i++) begin
      bit hit;
      ok = 0;
      for (int g = 0; g < 50 && !ok; g++) begin
        vv0 = 1;
        vd0 = vq[i];
        vl0 = (i == 3);
        hit = rdy0;
        step();
        if (hit) begin ok = 1; acc_hist[i] = cyc; end
      end
      if (!ok) begin
        failures++;
        $error("FAIL s0_accept_timeout observed=0 expected=1");
      end
      chk("s0_dut_in", din0, vq[i]);
    end
    vv0 = 0;
    for (int g = 0; g < 20 && !done0; g++) step();
    chk("s0_period", acc_hist[3] - acc_hist[0], 6);
    chk("s0_done", done0, 1);
    chk("s0_cnt", cnt0, 4);
    chk("s0_sig", sig0, es);
    chk("s0_mm", mm0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
